key_extract_ctl_pipe: RTL



---
 rtl/key_extract_ctl_pipe.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_extract_ctl_pipe.sv
// RMT stage key extractor: VLAN-indexed offset/mask lookup, key gather over the PHV,
// and an AXIS control path that writes the tables or forwards foreign packets.
module key_extract_ctl_pipe #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int KEY_EX_ID            = 1,
  parameter int SUB_UNIT_ID          = 0,
  parameter int NUM_CONT             = 64,
  parameter int CONT_W               = 32,
  parameter int NUM_KEY              = 8,
  parameter int TBL_DEPTH            = 32,
  parameter int C_VLANID_WIDTH       = 12,
  localparam int IDX_W      = $clog2(NUM_CONT),
  localparam int PHV_LEN    = NUM_CONT * CONT_W,
  localparam int KEY_LEN    = NUM_KEY * CONT_W,
  localparam int OFF_W      = NUM_KEY * IDX_W,
  localparam int MASK_BEATS = (KEY_LEN + 255) / 256,
  localparam int AW         = $clog2(TBL_DEPTH),
  localparam int KEEP_W     = C_S_AXIS_DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_valid_in,
  input  logic [C_VLANID_WIDTH-1:0]       vlan_in,
  input  logic                            vlan_in_valid,
  output logic                            ready_out,
  output logic [PHV_LEN-1:0]              phv_out,
  output logic [KEY_LEN-1:0]              key_out_masked,
  output logic                            key_hit_out,
  output logic                            out_valid,
  input  logic                            ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] c_s_axis_tuser,
  input  logic [KEEP_W-1:0]               c_s_axis_tkeep,
  input  logic                            c_s_axis_tvalid,
  input  logic                            c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]  c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0] c_m_axis_tuser,
  output logic [KEEP_W-1:0]               c_m_axis_tkeep,
  output logic                            c_m_axis_tvalid,
  output logic                            c_m_axis_tlast
);

  localparam int ACC_W = MASK_BEATS * C_S_AXIS_DATA_WIDTH;
  localparam int CNT_W = $clog2(MASK_BEATS + 1);

  typedef enum logic [2:0] {IDLE, HDR, WR_OFF, WR_MASK, DROP, FWD} state_t;

  // ---------------- tables ----------------
  logic [OFF_W-1:0]   off_tbl  [TBL_DEPTH];
  logic [KEY_LEN-1:0] mask_tbl [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] vld_tbl;

  // ---------------- control path ----------------
  state_t state_reg, state_next;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  b0_data_reg, hold_data_reg, cm_data_reg;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] b0_user_reg, hold_user_reg, cm_user_reg;
  logic [KEEP_W-1:0]               b0_keep_reg, hold_keep_reg, cm_keep_reg;
  logic hold_last_reg, pend_reg, cm_valid_reg, cm_last_reg;
  logic [7:0]       idx_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic b0_load, hold_load, emit, emit_hold, pend_next, idx_load, off_we, mask_we;
  logic [C_S_AXIS_DATA_WIDTH-1:0] swapped;
  logic [ACC_W-1:0] mask_cat;
  logic hdr_match, idx_ok, last_beat;
  logic [AW-1:0] wr_addr;

  assign hdr_match = (c_s_axis_tdata[115 +: 5] == 5'(STAGE_ID)) &&
                     (c_s_axis_tdata[112 +: 3] == 3'(KEY_EX_ID)) &&
                     (c_s_axis_tdata[124 +: 4] == 4'(SUB_UNIT_ID)) &&
                     (c_s_axis_tdata[64 +: 16] == 16'hf2f1);
  assign idx_ok    = {1'b0, idx_reg} < 9'(TBL_DEPTH);
  assign last_beat = cnt_reg == CNT_W'(MASK_BEATS - 1);
  assign wr_addr   = idx_reg[AW-1:0];

  // Payload byte 0 lands in the most significant byte.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_swap
      assign swapped[C_S_AXIS_DATA_WIDTH-1-8*gi -: 8] = c_s_axis_tdata[8*gi +: 8];
    end
    if (MASK_BEATS == 1) begin : g_acc_none
      assign mask_cat = swapped;
    end else begin : g_acc
      logic [ACC_W-1:0] acc_reg;
      assign mask_cat = {acc_reg[ACC_W-C_S_AXIS_DATA_WIDTH-1:0], swapped};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_reg <= '0;
        else if (state_reg == WR_MASK && c_s_axis_tvalid) acc_reg <= mask_cat;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (c_s_axis_tvalid && !c_s_axis_tlast) state_next = HDR;
      HDR:     if (c_s_axis_tvalid) begin
                 if (c_s_axis_tlast)  state_next = IDLE;
                 else if (hdr_match)  state_next = (c_s_axis_tdata[120 +: 4] == 4'd0) ? WR_OFF : WR_MASK;
                 else                 state_next = FWD;
               end
      WR_OFF:  if (c_s_axis_tvalid) state_next = c_s_axis_tlast ? IDLE : DROP;
      WR_MASK: if (c_s_axis_tvalid) begin
                 if (last_beat)           state_next = c_s_axis_tlast ? IDLE : DROP;
                 else if (c_s_axis_tlast) state_next = IDLE;
               end
      DROP,
      FWD:     if (c_s_axis_tvalid && c_s_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Foreign packets run one beat behind the input; a single-beat packet or the
  // final beat waits in the hold register and drains from IDLE (pend).
  always_comb begin
    b0_load = 1'b0; hold_load = 1'b0; emit = 1'b0; emit_hold = 1'b0;
    pend_next = 1'b0; idx_load = 1'b0; cnt_next = cnt_reg;
    off_we = 1'b0; mask_we = 1'b0;
    case (state_reg)
      IDLE: begin
        emit = pend_reg; emit_hold = 1'b1;
        if (c_s_axis_tvalid) begin
          if (c_s_axis_tlast) begin hold_load = 1'b1; pend_next = 1'b1; end
          else                b0_load = 1'b1;
        end
      end
      HDR: if (c_s_axis_tvalid) begin
        if (hdr_match) begin idx_load = 1'b1; cnt_next = '0; end
        else begin emit = 1'b1; hold_load = 1'b1; pend_next = c_s_axis_tlast; end
      end
      FWD: if (c_s_axis_tvalid) begin
        emit = 1'b1; emit_hold = 1'b1; hold_load = 1'b1; pend_next = c_s_axis_tlast;
      end
      WR_OFF:  if (c_s_axis_tvalid) off_we = idx_ok;
      WR_MASK: if (c_s_axis_tvalid) begin
        cnt_next = cnt_reg + 1'b1;
        mask_we  = last_beat & idx_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_data_reg <= '0; b0_user_reg <= '0; b0_keep_reg <= '0;
      hold_data_reg <= '0; hold_user_reg <= '0; hold_keep_reg <= '0; hold_last_reg <= 1'b0;
      cm_data_reg <= '0; cm_user_reg <= '0; cm_keep_reg <= '0;
      cm_valid_reg <= 1'b0; cm_last_reg <= 1'b0;
      pend_reg <= 1'b0; idx_reg <= '0; cnt_reg <= '0;
    end else begin
      if (b0_load) begin
        b0_data_reg <= c_s_axis_tdata; b0_user_reg <= c_s_axis_tuser; b0_keep_reg <= c_s_axis_tkeep;
      end
      if (hold_load) begin
        hold_data_reg <= c_s_axis_tdata; hold_user_reg <= c_s_axis_tuser;
        hold_keep_reg <= c_s_axis_tkeep; hold_last_reg <= c_s_axis_tlast;
      end
      if (idx_load) idx_reg <= c_s_axis_tdata[128 +: 8];
      pend_reg     <= pend_next;
      cnt_reg      <= cnt_next;
      cm_valid_reg <= emit;
      if (emit) begin
        cm_data_reg <= emit_hold ? hold_data_reg : b0_data_reg;
        cm_user_reg <= emit_hold ? hold_user_reg : b0_user_reg;
        cm_keep_reg <= emit_hold ? hold_keep_reg : b0_keep_reg;
        cm_last_reg <= emit_hold & hold_last_reg;
      end
    end
  end

  assign c_m_axis_tdata  = cm_data_reg;
  assign c_m_axis_tuser  = cm_user_reg;
  assign c_m_axis_tkeep  = cm_keep_reg;
  assign c_m_axis_tvalid = cm_valid_reg;
  assign c_m_axis_tlast  = cm_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        off_tbl[i]  <= '0;
        mask_tbl[i] <= '0;
      end
      vld_tbl <= '0;
    end else begin
      if (off_we) begin
        off_tbl[wr_addr] <= swapped[C_S_AXIS_DATA_WIDTH-1 -: OFF_W];
        vld_tbl[wr_addr] <= 1'b1;
      end
      if (mask_we) mask_tbl[wr_addr] <= mask_cat[ACC_W-1 -: KEY_LEN];
    end
  end

  // ---------------- data pipeline ----------------
  logic init_reg, s1_full_reg, s1_hit_reg, s1_adv, accept;
  logic [PHV_LEN-1:0] s1_phv_reg;
  logic [OFF_W-1:0]   s1_off_reg;
  logic [KEY_LEN-1:0] s1_mask_reg, key_raw;
  logic [AW-1:0]      rd_addr;
  logic unused_vlan;

  assign rd_addr     = vlan_in[4 +: AW];
  assign unused_vlan = ^vlan_in;
  assign s1_adv      = s1_full_reg & (~out_valid | ready_in);
  assign ready_out   = init_reg & (~s1_full_reg | s1_adv);
  assign accept      = phv_valid_in & vlan_in_valid & ready_out;

  generate
    for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
      logic [IDX_W-1:0] sel;
      assign sel = s1_off_reg[(NUM_KEY-1-gi)*IDX_W +: IDX_W];
      assign key_raw[(NUM_KEY-1-gi)*CONT_W +: CONT_W] = s1_phv_reg[int'(sel)*CONT_W +: CONT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_reg <= 1'b0; s1_full_reg <= 1'b0; s1_hit_reg <= 1'b0;
      s1_phv_reg <= '0; s1_off_reg <= '0; s1_mask_reg <= '0;
      out_valid <= 1'b0; phv_out <= '0; key_out_masked <= '0; key_hit_out <= 1'b0;
    end else begin
      init_reg <= 1'b1;
      if (accept) begin
        s1_full_reg <= 1'b1;
        s1_phv_reg  <= phv_in;
        s1_off_reg  <= off_tbl[rd_addr];
        s1_mask_reg <= mask_tbl[rd_addr];
        s1_hit_reg  <= vld_tbl[rd_addr];
      end else if (s1_adv) begin
        s1_full_reg <= 1'b0;
      end
      if (s1_adv) begin
        out_valid      <= 1'b1;
        phv_out        <= s1_phv_reg;
        key_out_masked <= s1_hit_reg ? (key_raw & s1_mask_reg) : '0;
        key_hit_out    <= s1_hit_reg;
      end else if (ready_in) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
